serial_digit_adder: RTL and testbench

- Parametrised, digit-serial multi-bit adder for the PE datapath, generalising the single-bit half-add cell.
- Adds two WIDTH-bit operands plus a carry-in, DIGIT bits per clock, with a registered carry between digits.
- Start/busy/done handshake; trades latency for area in the PE accumulate path.

---
 rtl/serial_digit_adder.sv | 116 +++++++++++
 tb/tb_serial_digit_adder.sv | 194 +++++++++++++++++++
 2 files changed

// File: rtl/serial_digit_adder.sv
// Digit-serial WIDTH-bit adder: DIGIT bits per clock with a registered inter-digit carry and start/busy/done handshake.
// Optional subtract mode (adds port sub) is enabled by defining SERIAL_DIGIT_ADDER_SUB_EN.
module serial_digit_adder #(
  parameter int WIDTH = 16,
  parameter int DIGIT = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
`ifdef SERIAL_DIGIT_ADDER_SUB_EN
  input  logic             sub,
`endif
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout
);
  localparam int N = WIDTH / DIGIT;
  localparam int CNT_W = (N > 1) ? $clog2(N) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(N - 1);

  generate
    if (DIGIT < 1 || DIGIT > WIDTH || (WIDTH % DIGIT) != 0) begin : g_bad_param
      $fatal(1, "serial_digit_adder: DIGIT must divide WIDTH and lie in 1..WIDTH");
    end
  endgenerate

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  function automatic logic [DIGIT:0] digit_add(input logic [DIGIT-1:0] x,
                                               input logic [DIGIT-1:0] y,
                                               input logic             c);
    digit_add = {1'b0, x} + {1'b0, y} + {{DIGIT{1'b0}}, c};
  endfunction

  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic             carry;
  logic [WIDTH-1:0] a_sr;
  logic [WIDTH-1:0] b_sr;
  logic [WIDTH-1:0] r_sr;

  logic [WIDTH-1:0]       b_load;
  logic                   c_load;
  logic [DIGIT:0]         dsum;
  logic [WIDTH+DIGIT-1:0] r_cat;
  logic [WIDTH-1:0]       r_next;

  // Subtraction is a + ~b + 1, so only the B load value and initial carry differ.
`ifdef SERIAL_DIGIT_ADDER_SUB_EN
  assign b_load = sub ? ~b : b;
  assign c_load = sub ? 1'b1 : cin;
`else
  assign b_load = b;
  assign c_load = cin;
`endif

  assign dsum   = digit_add(a_sr[DIGIT-1:0], b_sr[DIGIT-1:0], carry);
  assign r_cat  = {dsum[DIGIT-1:0], r_sr};
  assign r_next = r_cat[WIDTH+DIGIT-1:DIGIT];

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      busy  <= 1'b0;
      done  <= 1'b0;
      sum   <= '0;
      cout  <= 1'b0;
      cnt   <= '0;
      carry <= 1'b0;
      a_sr  <= '0;
      b_sr  <= '0;
      r_sr  <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE, DONE: begin
          if (start) begin
            a_sr  <= a;
            b_sr  <= b_load;
            carry <= c_load;
            cnt   <= '0;
            r_sr  <= '0;
            state <= RUN;
            busy  <= 1'b1;
          end else begin
            state <= IDLE;
            busy  <= 1'b0;
          end
        end
        RUN: begin
          a_sr  <= a_sr >> DIGIT;
          b_sr  <= b_sr >> DIGIT;
          r_sr  <= r_next;
          carry <= dsum[DIGIT];
          cnt   <= cnt + 1'b1;
          // Last digit: publish the completed result on this same edge.
          if (cnt == LAST) begin
            sum   <= r_next;
            cout  <= dsum[DIGIT];
            state <= DONE;
            busy  <= 1'b0;
            done  <= 1'b1;
          end
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_serial_digit_adder.sv
// Directed and table-driven bench for serial_digit_adder with DIGIT=4, DIGIT=1 and DIGIT=16 instances.
module tb_serial_digit_adder;
  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] a, b;
  logic        cin;
  logic        start_v [3];
  logic        busy_v  [3];
  logic        done_v  [3];
  logic [15:0] sum_v   [3];
  logic        cout_v  [3];
`ifdef SERIAL_DIGIT_ADDER_SUB_EN
  logic        sub;
`endif

  int checks = 0;
  int errors = 0;
  int nrun [3] = '{4, 16, 1};

  always #5 clk = ~clk;

  serial_digit_adder #(.WIDTH(16), .DIGIT(4)) u_d4 (
    .clk(clk), .rst(rst), .start(start_v[0]), .a(a), .b(b), .cin(cin),
`ifdef SERIAL_DIGIT_ADDER_SUB_EN
    .sub(sub),
`endif
    .busy(busy_v[0]), .done(done_v[0]), .sum(sum_v[0]), .cout(cout_v[0]));

  serial_digit_adder #(.WIDTH(16), .DIGIT(1)) u_d1 (
    .clk(clk), .rst(rst), .start(start_v[1]), .a(a), .b(b), .cin(cin),
`ifdef SERIAL_DIGIT_ADDER_SUB_EN
    .sub(sub),
`endif
    .busy(busy_v[1]), .done(done_v[1]), .sum(sum_v[1]), .cout(cout_v[1]));

  serial_digit_adder #(.WIDTH(16), .DIGIT(16)) u_d16 (
    .clk(clk), .rst(rst), .start(start_v[2]), .a(a), .b(b), .cin(cin),
`ifdef SERIAL_DIGIT_ADDER_SUB_EN
    .sub(sub),
`endif
    .busy(busy_v[2]), .done(done_v[2]), .sum(sum_v[2]), .cout(cout_v[2]));

  typedef struct {
    logic [15:0] a;
    logic [15:0] b;
    logic        cin;
    logic [16:0] exp;
  } vec_t;

  vec_t vecs [8];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  // One operation on instance k; returns at the negedge inside the DONE cycle (lat=0 on timeout).
  task automatic run_op(input int k, input logic [15:0] ta, input logic [15:0] tb,
                        input logic tc, input logic tsub,
                        output logic [15:0] s, output logic c, output int lat, output int bcnt);
    @(negedge clk);
    a = ta; b = tb; cin = tc;
`ifdef SERIAL_DIGIT_ADDER_SUB_EN
    sub = tsub;
`else
    if (tsub) $display("note: subtract requested in add-only build");
`endif
    start_v[k] = 1'b1;
    lat = 0;
    bcnt = 0;
    for (int i = 1; i <= 40; i++) begin
      @(negedge clk);
      start_v[k] = 1'b0;
      if (busy_v[k]) bcnt++;
      if (done_v[k]) begin
        lat = i;
        break;
      end
    end
    s = sum_v[k];
    c = cout_v[k];
  endtask

  logic [15:0] s, ta, tb;
  logic        c, tc, held;
  int          lat, bc, seen;

  initial begin
    vecs[0] = '{16'hFFFF, 16'h0001, 1'b0, 17'h10000};
    vecs[1] = '{16'h1234, 16'h4321, 1'b1, 17'h05556};
    vecs[2] = '{16'h8000, 16'h8000, 1'b0, 17'h10000};
    vecs[3] = '{16'h0000, 16'h0000, 1'b0, 17'h00000};
    vecs[4] = '{16'hFFFF, 16'hFFFF, 1'b1, 17'h1FFFF};
    vecs[5] = '{16'h0FFF, 16'h0001, 1'b0, 17'h01000};
    vecs[6] = '{16'h0000, 16'hFFFF, 1'b1, 17'h10000};
    vecs[7] = '{16'hA5A5, 16'h5A5A, 1'b0, 17'h0FFFF};

    rst = 1'b1; a = '0; b = '0; cin = 1'b0;
`ifdef SERIAL_DIGIT_ADDER_SUB_EN
    sub = 1'b0;
`endif
    for (int k = 0; k < 3; k++) start_v[k] = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    for (int k = 0; k < 3; k++)
      chk($sformatf("reset_state_%0d", k), {busy_v[k], done_v[k], cout_v[k], sum_v[k]}, 32'h0);

    for (int i = 0; i < 8; i++) begin
      run_op(0, vecs[i].a, vecs[i].b, vecs[i].cin, 1'b0, s, c, lat, bc);
      chk($sformatf("vec%0d_result", i), {c, s}, vecs[i].exp);
      chk($sformatf("vec%0d_latency", i), lat, 5);
      chk($sformatf("vec%0d_busy_cycles", i), bc, 4);
    end

    // Back-to-back: start accepted in the DONE cycle, first result held meanwhile.
    run_op(0, 16'h1234, 16'h4321, 1'b1, 1'b0, s, c, lat, bc);
    chk("b2b_first", {c, s}, 17'h05556);
    a = 16'h8000; b = 16'h8000; cin = 1'b0; start_v[0] = 1'b1;
    held = 1'b1; lat = 0;
    for (int i = 1; i <= 40; i++) begin
      @(negedge clk);
      start_v[0] = 1'b0;
      if (i == 1) chk("b2b_no_gap_busy", busy_v[0], 1);
      if (!done_v[0] && {cout_v[0], sum_v[0]} !== 17'h05556) held = 1'b0;
      if (done_v[0]) begin
        lat = i;
        break;
      end
    end
    chk("b2b_held", held, 1);
    chk("b2b_latency", lat, 5);
    chk("b2b_second", {cout_v[0], sum_v[0]}, 17'h10000);

    // start and operands toggled throughout RUN must be ignored.
    @(negedge clk);
    a = 16'h1111; b = 16'h2222; cin = 1'b0; start_v[0] = 1'b1;
    lat = 0;
    for (int i = 1; i <= 40; i++) begin
      @(negedge clk);
      if (done_v[0]) begin
        start_v[0] = 1'b0;
        lat = i;
        break;
      end
      a = 16'($urandom); b = 16'($urandom); cin = 1'b1;
    end
    chk("ignore_start_latency", lat, 5);
    chk("ignore_start_result", {cout_v[0], sum_v[0]}, 17'h03333);

    // Reset during the second RUN cycle discards the partial result.
    @(negedge clk);
    a = 16'h0001; b = 16'h0001; cin = 1'b0; start_v[0] = 1'b1;
    @(negedge clk);
    start_v[0] = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("midrun_reset_outputs", {busy_v[0], done_v[0], cout_v[0], sum_v[0]}, 32'h0);
    seen = 0;
    repeat (8) begin
      @(negedge clk);
      if (done_v[0] || busy_v[0]) seen++;
    end
    chk("midrun_reset_no_done", seen, 0);

    // DIGIT=1 and DIGIT=16 instances against a+b+cin.
    for (int k = 1; k < 3; k++) begin
      for (int i = 0; i < 1000; i++) begin
        ta = 16'($urandom); tb = 16'($urandom); tc = 1'($urandom);
        run_op(k, ta, tb, tc, 1'b0, s, c, lat, bc);
        chk($sformatf("rand_d%0d_%0d_result", nrun[k], i), {c, s},
            17'({1'b0, ta} + {1'b0, tb} + {16'h0, tc}));
        chk($sformatf("rand_d%0d_%0d_latency", nrun[k], i), lat, nrun[k] + 1);
      end
    end

`ifdef SERIAL_DIGIT_ADDER_SUB_EN
    run_op(0, 16'h0005, 16'h0007, 1'b0, 1'b1, s, c, lat, bc);
    chk("sub_5_minus_7", {c, s}, 17'h0FFFE);
    run_op(0, 16'h0007, 16'h0005, 1'b0, 1'b1, s, c, lat, bc);
    chk("sub_7_minus_5", {c, s}, 17'h10002);
    chk("sub_latency", lat, 5);
    run_op(0, 16'h0007, 16'h0005, 1'b1, 1'b0, s, c, lat, bc);
    chk("sub_off_add", {c, s}, 17'h0000D);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
